student_fir_seq: RTL and testbench

Sequencer for the student FIR datapath. It accepts a sample from one of two sources:
- the streaming strobe input, or
- the bus-mapped sample-write register.

It writes the sample into the circular sample DPRAM, then walks all taps by driving the sample and coefficient DPRAM read ports, and performs the signed multiply-accumulate. It emits a saturated result together with the sample-shift value and a one-cycle valid strobe. It sits between the bus register block and the two DPRAMs inside student_fir.

---
 rtl/student_fir_seq.sv | 137 +++++++++++++
 tb/tb_student_fir_seq.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/student_fir_seq.sv
// FIR sequencer: latch a sample, write it into the circular window, then walk all taps doing a signed MAC.
// Latency: valid_o rises N+3 clock edges after the accepting edge.
// Backpressure: none; any strobe arriving while busy (or on the DONE cycle) is discarded with a drop_o pulse.
module student_fir_seq #(
    parameter int ADDR_WIDTH        = 10,
    parameter int DATA_SIZE         = 16,
    parameter int DATA_SIZE_FIR_OUT = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         hw_valid_i,
    input  logic [DATA_SIZE-1:0]         hw_sample_i,
    input  logic                         reg_valid_i,
    input  logic [DATA_SIZE-1:0]         reg_sample_i,
    output logic                         busy_o,
    output logic                         drop_o,
    output logic                         smp_we_o,
    output logic [ADDR_WIDTH-1:0]        smp_waddr_o,
    output logic [DATA_SIZE-1:0]         smp_wdata_o,
    output logic [ADDR_WIDTH-1:0]        smp_raddr_o,
    input  logic [DATA_SIZE-1:0]         smp_rdata_i,
    output logic [ADDR_WIDTH-1:0]        coef_raddr_o,
    input  logic [DATA_SIZE-1:0]         coef_rdata_i,
    output logic [DATA_SIZE_FIR_OUT-1:0] y_o,
    output logic [DATA_SIZE-1:0]         sample_shift_o,
    output logic                         valid_o
);

    localparam int ACC_W  = 2*DATA_SIZE + ADDR_WIDTH;
    localparam int PROD_W = 2*DATA_SIZE;
    localparam logic [ADDR_WIDTH-1:0] LAST_TAP = '1;

    typedef enum logic [2:0] {IDLE, WRITE, RUN, DRAIN, DONE} state_t;

    state_t                         state, state_nxt;
    logic [ADDR_WIDTH-1:0]          wp;
    logic [ADDR_WIDTH-1:0]          k;
    logic [DATA_SIZE-1:0]           sample_q;
    logic [DATA_SIZE-1:0]           shift_q;
    logic signed [ACC_W-1:0]        acc;
    logic signed [PROD_W-1:0]       prod;
    logic signed [ACC_W-1:0]        prod_ext;
    logic signed [DATA_SIZE_FIR_OUT-1:0] y_sat;
    logic                           strobe;
    logic                           acc_en;

    assign strobe   = hw_valid_i | reg_valid_i;
    assign prod     = $signed(smp_rdata_i) * $signed(coef_rdata_i);
    assign prod_ext = {{ADDR_WIDTH{prod[PROD_W-1]}}, prod};
    // Read data lags the address by one cycle, so the first RUN cycle has nothing to add yet.
    assign acc_en   = ((state == RUN) && (k != '0)) || (state == DRAIN);

    // Clamp the wide accumulator into the signed output range.
    generate
        if (ACC_W > DATA_SIZE_FIR_OUT) begin : g_sat
            logic [ACC_W-DATA_SIZE_FIR_OUT:0] upper;
            assign upper = acc[ACC_W-1:DATA_SIZE_FIR_OUT-1];
            always_comb begin
                y_sat = acc[DATA_SIZE_FIR_OUT-1:0];
                if (!((&upper) || (~|upper))) begin
                    y_sat = acc[ACC_W-1] ? {1'b1, {(DATA_SIZE_FIR_OUT-1){1'b0}}}
                                         : {1'b0, {(DATA_SIZE_FIR_OUT-1){1'b1}}};
                end
            end
        end else if (ACC_W == DATA_SIZE_FIR_OUT) begin : g_same
            assign y_sat = acc;
        end else begin : g_ext
            assign y_sat = {{(DATA_SIZE_FIR_OUT-ACC_W){acc[ACC_W-1]}}, acc};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic: one write cycle, N read cycles, one drain cycle, one result cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (strobe) state_nxt = WRITE;
            WRITE:   state_nxt = RUN;
            RUN:     if (k == LAST_TAP) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: sample latch, tap counter, accumulator, head pointer and result registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wp             <= '0;
            k              <= '0;
            sample_q       <= '0;
            shift_q        <= '0;
            acc            <= '0;
            y_o            <= '0;
            sample_shift_o <= '0;
            valid_o        <= 1'b0;
            drop_o         <= 1'b0;
        end else begin
            valid_o <= (state == DONE);
            // Busy strobes are lost; a simultaneous pair in IDLE loses the bus-side one.
            drop_o  <= strobe && ((state != IDLE) || (hw_valid_i && reg_valid_i));
            if (state == IDLE && strobe) begin
                sample_q <= hw_valid_i ? hw_sample_i : reg_sample_i;
            end
            if (state == WRITE) begin
                k   <= '0;
                acc <= '0;
            end else begin
                if (state == RUN) k <= k + ADDR_WIDTH'(1);
                if (acc_en)       acc <= acc + prod_ext;
            end
            // The word returned during DRAIN belongs to the oldest tap.
            if (state == DRAIN) shift_q <= smp_rdata_i;
            if (state == DONE) begin
                y_o            <= y_sat;
                sample_shift_o <= shift_q;
                wp             <= wp + ADDR_WIDTH'(1);
            end
        end
    end

    // DPRAM port drive; reads and writes live in disjoint states so they never collide.
    always_comb begin
        busy_o       = (state != IDLE);
        smp_we_o     = (state == WRITE);
        smp_waddr_o  = (state == WRITE) ? wp : '0;
        smp_wdata_o  = sample_q;
        smp_raddr_o  = (state == RUN) ? (wp - k) : '0;
        coef_raddr_o = (state == RUN) ? k : '0;
    end

endmodule

// File: tb/tb_student_fir_seq.sv
// Bench for student_fir_seq with N=4 taps: behavioural DPRAM models plus a window-based reference filter.
module tb_student_fir_seq;

    localparam int AW = 2;
    localparam int DS = 16;
    localparam int DO = 32;
    localparam int N  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          hw_valid = 1'b0, reg_valid = 1'b0;
    logic [DS-1:0] hw_sample = '0, reg_sample = '0;
    logic          busy, drop, smp_we, valid;
    logic [AW-1:0] smp_waddr, smp_raddr, coef_raddr;
    logic [DS-1:0] smp_wdata, smp_rdata, coef_rdata, sample_shift;
    logic [DO-1:0] y;

    student_fir_seq #(.ADDR_WIDTH(AW), .DATA_SIZE(DS), .DATA_SIZE_FIR_OUT(DO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .hw_valid_i(hw_valid), .hw_sample_i(hw_sample),
        .reg_valid_i(reg_valid), .reg_sample_i(reg_sample),
        .busy_o(busy), .drop_o(drop),
        .smp_we_o(smp_we), .smp_waddr_o(smp_waddr), .smp_wdata_o(smp_wdata),
        .smp_raddr_o(smp_raddr), .smp_rdata_i(smp_rdata),
        .coef_raddr_o(coef_raddr), .coef_rdata_i(coef_rdata),
        .y_o(y), .sample_shift_o(sample_shift), .valid_o(valid)
    );

    always #5 clk = ~clk;

    // Memory models and event monitors.
    logic [DS-1:0] smem [N];
    logic [DS-1:0] cmem [N];
    logic          mem_fill = 1'b0;
    logic [DS-1:0] fill_val = '0;
    int            drop_cnt = 0, valid_cnt = 0;
    logic [AW-1:0] last_waddr = '0;
    logic [DS-1:0] last_wdata = '0;

    always @(posedge clk) begin
        if (mem_fill) begin
            for (int i = 0; i < N; i++) smem[i] <= fill_val;
        end else if (smp_we) begin
            smem[smp_waddr] <= smp_wdata;
        end
        smp_rdata  <= smem[smp_raddr];
        coef_rdata <= cmem[coef_raddr];
        if (drop)   drop_cnt  <= drop_cnt + 1;
        if (valid)  valid_cnt <= valid_cnt + 1;
        if (smp_we) begin
            last_waddr <= smp_waddr;
            last_wdata <= smp_wdata;
        end
    end

    // Reference: the window is an array indexed by head pointer; y is the plain dot product.
    logic signed [DS-1:0] ref_mem [N];
    int                   ref_wp;
    int                   tests = 0, fails = 0;

    task automatic ref_accept(input logic [DS-1:0] s, output logic [DO-1:0] y_exp,
                              output logic [DS-1:0] sh_exp);
        longint sum = 0;
        logic signed [DS-1:0] c;
        ref_mem[ref_wp] = s;
        for (int t = 0; t < N; t++) begin
            c = cmem[t];
            sum += longint'(ref_mem[(ref_wp - t + N) % N]) * longint'(c);
        end
        if (sum > 64'sd2147483647)       y_exp = 32'h7FFF_FFFF;
        else if (sum < -64'sd2147483648) y_exp = 32'h8000_0000;
        else                             y_exp = sum[31:0];
        sh_exp = ref_mem[(ref_wp + 1) % N];
        ref_wp = (ref_wp + 1) % N;
    endtask

    task automatic apply_reset(input logic [DS-1:0] cval);
        @(negedge clk);
        rst_n = 1'b0; hw_valid = 1'b0; reg_valid = 1'b0;
        mem_fill = 1'b1; fill_val = '0;
        for (int i = 0; i < N; i++) begin cmem[i] = cval; ref_mem[i] = '0; end
        ref_wp = 0;
        repeat (2) @(negedge clk);
        mem_fill = 1'b0; rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Drive one strobe and wait for valid; optionally inject a hw strobe after edge inject_at.
    task automatic run_sample(input logic use_hw, input logic use_reg,
                              input logic [DS-1:0] hs, input logic [DS-1:0] rs,
                              input int inject_at, output int lat);
        @(negedge clk);
        hw_valid = use_hw; hw_sample = hs; reg_valid = use_reg; reg_sample = rs;
        @(posedge clk); #1;
        hw_valid = 1'b0; reg_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            hw_valid = (i == inject_at);
            if (i == inject_at) hw_sample = 16'h0077;
            if (valid) begin lat = i; break; end
        end
        hw_valid = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset(16'h0002);
        tests++;
        if ({y, sample_shift, valid, busy, drop, smp_we, smp_waddr, smp_raddr, coef_raddr} !== '0) begin
            fails++;
            $display("FAIL reset_state: y=%h shift=%h valid=%b busy=%b drop=%b we=%b wa=%0d ra=%0d ca=%0d required all zero",
                     y, sample_shift, valid, busy, drop, smp_we, smp_waddr, smp_raddr, coef_raddr);
        end
    endtask

    task automatic test_stream();
        logic [DO-1:0] ye [5] = '{32'd2, 32'd6, 32'd12, 32'd20, 32'd28};
        logic [DS-1:0] se [5] = '{16'd0, 16'd0, 16'd0, 16'd1, 16'd2};
        logic [DO-1:0] yr; logic [DS-1:0] sr; int lat;
        apply_reset(16'h0002);
        for (int i = 0; i < 5; i++) begin
            ref_accept(DS'(i + 1), yr, sr);
            run_sample(1'b1, 1'b0, DS'(i + 1), '0, 0, lat);
            tests++;
            if (y !== ye[i] || y !== yr) begin
                fails++; $display("FAIL stream_y[%0d]: got %0d required %0d", i, y, ye[i]);
            end
            tests++;
            if (sample_shift !== se[i] || sample_shift !== sr) begin
                fails++; $display("FAIL stream_shift[%0d]: got %0d required %0d", i, sample_shift, se[i]);
            end
            tests++;
            if (lat !== 7) begin
                fails++; $display("FAIL stream_latency[%0d]: got %0d required 7", i, lat);
            end
        end
    endtask

    task automatic test_reg_write();
        logic [DO-1:0] yr; logic [DS-1:0] sr; int lat; int wp_before;
        apply_reset(16'h0002);
        wp_before = ref_wp;
        ref_accept(16'h0001, yr, sr);
        run_sample(1'b0, 1'b1, '0, 16'h0001, 0, lat);
        tests++;
        if (y !== 32'd2 || lat !== 7) begin
            fails++; $display("FAIL reg_write_y: got %0d lat %0d required 2 lat 7", y, lat);
        end
        tests++;
        if (int'(last_waddr) !== wp_before || last_wdata !== 16'h0001) begin
            fails++; $display("FAIL reg_write_addr: got addr %0d data %h required addr %0d data 0001",
                              last_waddr, last_wdata, wp_before);
        end
    endtask

    task automatic test_collision();
        logic [DO-1:0] yr; logic [DS-1:0] sr; int lat; int d0, v0;
        apply_reset(16'h0002);
        d0 = drop_cnt; v0 = valid_cnt;
        ref_accept(16'd3, yr, sr);
        run_sample(1'b1, 1'b1, 16'd3, 16'd9, 3, lat);
        repeat (10) @(posedge clk);
        #1;
        tests++;
        if (y !== 32'd6 || y !== yr) begin
            fails++; $display("FAIL collision_y: got %0d required 6", y);
        end
        tests++;
        if (drop_cnt - d0 !== 2) begin
            fails++; $display("FAIL collision_drops: got %0d required 2", drop_cnt - d0);
        end
        tests++;
        if (valid_cnt - v0 !== 1 || busy !== 1'b0) begin
            fails++; $display("FAIL collision_valids: got %0d busy %b required 1 busy 0", valid_cnt - v0, busy);
        end
    endtask

    task automatic test_done_drop();
        logic [DO-1:0] yr; logic [DS-1:0] sr; int lat; int d0, v0;
        apply_reset(16'h0002);
        d0 = drop_cnt; v0 = valid_cnt;
        ref_accept(16'd5, yr, sr);
        run_sample(1'b1, 1'b0, 16'd5, '0, 6, lat);
        repeat (10) @(posedge clk);
        #1;
        tests++;
        if (drop_cnt - d0 !== 1 || valid_cnt - v0 !== 1 || y !== yr) begin
            fails++; $display("FAIL done_cycle_drop: drops %0d valids %0d y %0d required 1 1 %0d",
                              drop_cnt - d0, valid_cnt - v0, y, yr);
        end
    endtask

    task automatic test_saturation();
        logic [DO-1:0] yr; logic [DS-1:0] sr; int lat;
        apply_reset(16'hFFFF);
        ref_accept(16'h7FFF, yr, sr);
        run_sample(1'b1, 1'b0, 16'h7FFF, '0, 0, lat);
        tests++;
        if (y !== 32'hFFFF_8001 || y !== yr) begin
            fails++; $display("FAIL neg_coef: got %h required ffff8001", y);
        end
        apply_reset(16'h8000);
        @(negedge clk); mem_fill = 1'b1; fill_val = 16'h8000;
        @(negedge clk); mem_fill = 1'b0;
        for (int i = 0; i < N; i++) ref_mem[i] = 16'sh8000;
        ref_accept(16'h8000, yr, sr);
        run_sample(1'b1, 1'b0, 16'h8000, '0, 0, lat);
        tests++;
        if (y !== 32'h7FFF_FFFF || y !== yr) begin
            fails++; $display("FAIL sat_pos: got %h required 7fffffff", y);
        end
        for (int i = 0; i < N; i++) cmem[i] = 16'h7FFF;
        ref_accept(16'h8000, yr, sr);
        run_sample(1'b1, 1'b0, 16'h8000, '0, 0, lat);
        tests++;
        if (y !== 32'h8000_0000 || y !== yr) begin
            fails++; $display("FAIL sat_neg: got %h required 80000000", y);
        end
    endtask

    task automatic test_random();
        logic [DO-1:0] yr; logic [DS-1:0] sr, s; int lat; logic h;
        apply_reset(16'h0000);
        for (int i = 0; i < N; i++) cmem[i] = DS'($urandom);
        for (int n = 0; n < 12; n++) begin
            s = DS'($urandom);
            h = 1'($urandom_range(0, 1));
            ref_accept(s, yr, sr);
            run_sample(h, !h, s, s, 0, lat);
            tests++;
            if (y !== yr || sample_shift !== sr || lat !== 7) begin
                fails++; $display("FAIL random[%0d]: y %h shift %h lat %0d required y %h shift %h lat 7",
                                  n, y, sample_shift, lat, yr, sr);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [DO-1:0] yr; logic [DS-1:0] sr; int lat; int v0;
        apply_reset(16'h0002);
        ref_accept(16'd11, yr, sr); run_sample(1'b1, 1'b0, 16'd11, '0, 0, lat);
        ref_accept(16'd12, yr, sr); run_sample(1'b1, 1'b0, 16'd12, '0, 0, lat);
        @(negedge clk); hw_valid = 1'b1; hw_sample = 16'd13;
        @(posedge clk); #1; hw_valid = 1'b0;
        ref_mem[ref_wp] = 16'sd13;
        repeat (3) @(posedge clk);
        #1; v0 = valid_cnt; rst_n = 1'b0; #1;
        tests++;
        if ({y, sample_shift, valid, busy, smp_we, smp_raddr, coef_raddr} !== '0) begin
            fails++; $display("FAIL reset_mid_run: y=%h shift=%h valid=%b busy=%b we=%b ra=%0d ca=%0d required all zero",
                              y, sample_shift, valid, busy, smp_we, smp_raddr, coef_raddr);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1; ref_wp = 0;
        repeat (8) @(negedge clk);
        tests++;
        if (valid_cnt !== v0) begin
            fails++; $display("FAIL reset_no_valid: got %0d valids required 0", valid_cnt - v0);
        end
        ref_accept(16'd20, yr, sr);
        run_sample(1'b1, 1'b0, 16'd20, '0, 0, lat);
        tests++;
        if (last_waddr !== '0 || y !== yr || sample_shift !== sr) begin
            fails++; $display("FAIL reset_restart: addr %0d y %0d shift %0d required addr 0 y %0d shift %0d",
                              last_waddr, y, sample_shift, yr, sr);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_reg_write();
        test_collision();
        test_done_drop();
        test_saturation();
        test_random();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
